// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_arbiter8_pkg;

    // Number of requesters and the width of an encoded requester index.
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // Arbiter state: either nobody owns the resource, or one requester does.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter8_decoder.sv
// 3-to-8 one-hot decoder used to expand the encoded grant index.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows sel directly.
//
// Ports:
//   sel  - encoded index, 3 bits
//   dec  - one-hot expansion of sel, 8 bits
module decoder_3to8
    import rr_arbiter8_pkg::*;
(
    input  logic [IDX_W-1:0] sel,
    output logic [N_REQ-1:0] dec
);

    always_comb begin
        dec      = '0;
        dec[sel] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one resource among 8 requesters, with hold-time limit.
// Latency: grant registered 1 cycle after request; 1-cycle idle gap after every grant.
// Backpressure: owner keeps the grant until rel, request drop, or HOLD_MAX cycles.
//
// Ports:
//   clk        - clock, all state on the rising edge
//   reset      - synchronous, active-high reset
//   req[7:0]   - request vector, bit i belongs to requester i
//   rel        - current owner frees the resource this cycle ("release" is a
//                reserved word, hence the short name)
//   gnt[7:0]   - one-hot grant, all zero when nobody owns the resource
//   gnt_id     - encoded owner index, meaningful only while gnt_valid=1
//   gnt_valid  - a grant is active
//   timeout    - one-cycle pulse when a grant is revoked by the hold limit
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    // Counter value seen during the last cycle a grant may legally be held.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W-1:0] sel_idx;
    logic [N_REQ-1:0] dec;
    logic             owner_gone;

    // Rotate the request vector so bit 0 is the requester at ptr; the 3-bit
    // index addition wraps mod 8 on its own.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[ptr + IDX_W'(i)];
        end
    end

    // Fixed priority encoder on the rotated vector: lowest set bit wins.
    // Scanning from the top down leaves the lowest index as the final value.
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    // Undo the rotation to recover the absolute requester index.
    assign sel_idx = ptr + off;

    // A voluntary exit (release or the owner dropping its request) always
    // takes precedence over the hold limit, so no timeout pulse is produced.
    assign owner_gone = rel || !req[gnt_id];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // rel is ignored here; any request starts a new grant.
                    if (|req) begin
                        gnt_id    <= sel_idx;
                        hold_cnt  <= '0;
                        gnt_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (owner_gone) begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_id + IDX_W'(1);
                        hold_cnt  <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b1;
                        ptr       <= gnt_id + IDX_W'(1);
                        hold_cnt  <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    decoder_3to8 u_dec (
        .sel (gnt_id),
        .dec (dec)
    );

    // The decoder always drives one bit; gate it so gnt is zero with no owner.
    assign gnt = dec & {N_REQ{gnt_valid}};

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized traffic.
// Latency: outputs checked every falling edge against a behavioural model.
// Backpressure: n/a.
module tb_rr_arbiter8;

    localparam int HOLD_MAX = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic       rel = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter8 #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who owns the resource, how many cycles it has held
    // it, and who has first priority next.
    // ------------------------------------------------------------------
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_held  = 0;
    bit   m_to    = 1'b0;
    bit   live    = 1'b0;
    logic [7:0] s_req;
    logic s_rel;
    logic s_rst;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    // Capture inputs exactly as the DUT samples them.
    initial forever begin
        @(posedge clk);
        s_req = req;
        s_rel = rel;
        s_rst = reset;
        live  = 1'b1;
    end

    // Advance the model by one clock, then compare every visible output.
    initial forever begin
        @(negedge clk);
        if (live) begin
            if (s_rst) begin
                m_owner = -1; m_ptr = 0; m_held = 0; m_to = 1'b0;
            end else if (m_owner < 0) begin
                m_to = 1'b0;
                if (s_req != 8'h00) begin
                    m_owner = pick(s_req, m_ptr);
                    m_held  = 1;
                end
            end else if (s_rel || !s_req[m_owner]) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1; m_to = 1'b0;
            end else if (m_held == HOLD_MAX) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1; m_to = 1'b1;
            end else begin
                m_held++;
            end

            check("m_gnt_valid", gnt_valid, (m_owner >= 0) ? 1 : 0);
            check("m_gnt", gnt, (m_owner >= 0) ? (1 << m_owner) : 0);
            if (m_owner >= 0) check("m_gnt_id", gnt_id, m_owner);
            check("m_timeout", timeout, m_to);
            check("m_ptr", dut.ptr, m_ptr);
        end
    end

    // Hard bound on the whole run.
    initial begin
        #2000000;
        $display("FAIL watchdog run did not complete actual=running required=finished");
        $fatal(1, "watchdog");
    end

    int got[$];
    int exp_ord[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int hold;
    bit seen_to;
    int r;

    initial begin
        // Reset then idle.
        reset = 1'b1; req = 8'h00; rel = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_gnt", gnt, 8'h00);
            check("rst_valid", gnt_valid, 0);
            check("rst_id", gnt_id, 0);
            check("rst_timeout", timeout, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("idle_gnt", gnt, 8'h00);

        // Single request from requester 4, released after two grant cycles.
        req = 8'h10;
        @(negedge clk);
        check("single_gnt", gnt, 8'h10);
        check("single_id", gnt_id, 4);
        @(negedge clk);
        rel = 1'b1;
        @(negedge clk);
        check("single_drop", gnt, 8'h00);
        check("single_ptr", dut.ptr, 5);
        rel = 1'b0; req = 8'h00;
        @(negedge clk);

        // Full rotation with everybody requesting.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; req = 8'hFF;
        for (int c = 0; c < 60 && got.size() < 9; c++) begin
            @(negedge clk);
            if (gnt_valid) begin
                got.push_back(int'(gnt_id));
                rel = 1'b1;
            end else begin
                rel = 1'b0;
            end
        end
        check("rot_count", got.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < got.size()) check("rot_order", got[i], exp_ord[i]);
        end
        req = 8'h00; rel = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Hold-limit revocation with a lone requester 1.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; req = 8'h02;
        hold = 0; seen_to = 1'b0;
        for (int c = 0; c < 20 && !seen_to; c++) begin
            @(negedge clk);
            if (gnt == 8'h02) begin
                hold++;
            end else if (hold > 0) begin
                check("to_pulse", timeout, 1);
                check("to_gap_gnt", gnt, 8'h00);
                seen_to = 1'b1;
            end
        end
        check("to_hold_cycles", hold, 4);
        check("to_seen", seen_to, 1);
        @(negedge clk);
        check("to_regrant", gnt, 8'h02);
        check("to_pulse_width", timeout, 0);

        // Release in the final allowed cycle: no timeout pulse.
        repeat (3) @(negedge clk);
        check("tie_still_held", gnt, 8'h02);
        rel = 1'b1;
        @(negedge clk);
        check("tie_timeout", timeout, 0);
        check("tie_valid", gnt_valid, 0);
        rel = 1'b0;
        @(negedge clk);
        check("drop_grant", gnt, 8'h02);
        req = 8'h00;
        @(negedge clk);
        check("drop_valid", gnt_valid, 0);
        check("drop_ptr", dut.ptr, 2);

        // Reset in the middle of a grant.
        req = 8'h08;
        @(negedge clk);
        check("mid_gnt", gnt, 8'h08);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_gnt", gnt, 8'h00);
        check("mid_rst_ptr", dut.ptr, 0);
        check("mid_rst_timeout", timeout, 0);
        reset = 1'b0; req = 8'h88;
        @(negedge clk);
        check("post_rst_id", gnt_id, 3);
        check("post_rst_gnt", gnt, 8'h08);
        req = 8'h00;
        @(negedge clk);

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) == 0);
            rel   = ($urandom_range(0, 5) == 0);
            r = int'($urandom_range(0, 5));
            case (r)
                0: req = 8'($urandom);
                1: req = req | (8'h01 << $urandom_range(0, 7));
                2: req = req & ~(8'h01 << $urandom_range(0, 7));
                default: req = req;
            endcase
        end
        reset = 1'b0; rel = 1'b0; req = 8'h00;
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Holds each grant until the owner releases it, drops its request, or hits a hold-time limit.
- Grant index is kept 3-bit encoded internally and expanded to a one-hot grant vector by the team's 3-to-8 decoder.
- Sits in front of any single-owner resource: shared bus, memory port or functional unit.

Parameters:
- HOLD_MAX, 15: maximum cycles one grant may be held before forced revocation; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request vector, bit i = requester i.
- release  input  1  current owner frees the resource this cycle.
- gnt  output  8  one-hot grant, all-zero when no owner.
- gnt_id  output  3  encoded owner index, valid only when gnt_valid=1.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - gnt = 8'h00, gnt_id = 0, gnt_valid = 0, timeout = 0.
  - ptr (priority pointer) = 0, hold counter = 0.
- Reset asserted during GRANT drops gnt the next edge; no timeout pulse is produced.
- All outputs are registered. gnt equals decode(gnt_id) gated by gnt_valid.
- Priority selection: first set bit of req scanning ptr, ptr+1, ..., ptr+7, with indices taken mod 8.
- IDLE state:
  - req == 0: stay in IDLE.
  - Otherwise: latch the selected index into gnt_id, clear the hold counter, go to GRANT.
  - gnt_valid rises on the edge after req is sampled (1-cycle latency).
- GRANT state, hold counter increments each cycle. Exit to IDLE when any of:
  - release = 1.
  - req[gnt_id] = 0.
  - hold counter == HOLD_MAX-1 with neither of the above; this also pulses timeout for exactly one cycle, aligned with gnt_valid falling.
- Simultaneous exit events: release or request drop wins over timeout, so no pulse is produced.
- On every exit from GRANT: ptr <= gnt_id + 1 mod 8, so 7 wraps to 0.
- Mandatory one-cycle gap: the IDLE cycle after GRANT always has gnt = 0. Earliest regrant is 2 cycles after the release edge.
- No reclaiming during the gap: a requester that stays asserted through the gap competes again with lowest priority.
- release while in IDLE is ignored.
- Changes to req bits other than the owner's during GRANT are ignored.
- Fairness: with all 8 requesting continuously, every requester is granted once in any 8 consecutive grants.

Decomposition:
- Shared package:
  - State encoding typedef: IDLE = 1'b0, GRANT = 1'b1.
  - Constants: N_REQ = 8 and IDX_W = 3.
- Sub-module decoder_3to8 (existing block) produces gnt from gnt_id. The arbiter ANDs its output with gnt_valid.
- Priority search is a rotate-by-ptr followed by a fixed priority encoder, inside the arbiter.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, req=0 -> gnt=8'h00, gnt_valid=0, gnt_id=0 throughout.
- Single request: req=8'h10 at cycle t -> at t+1 gnt=8'h10, gnt_id=4. Then release at t+3 -> gnt=0 at t+4 and ptr=5.
- Full rotation: req=8'hFF held, release each time after 1 grant cycle -> grant order 0,1,2,3,4,5,6,7,0, each separated by one gap cycle; 7->0 wrap is checked.
- Timeout: HOLD_MAX=4, req=8'h02 held, release=0 -> gnt=8'h02 for exactly 4 cycles. timeout=1 in the cycle gnt drops. Regrant to 1 after the gap since it is the only requester.
- Tie and simultaneous events:
  - release and counter == HOLD_MAX-1 in the same cycle -> timeout stays 0.
  - The owner dropping req mid-grant ends the grant on the next edge with ptr advanced.
- Reset mid-grant: gnt=8'h08 active, reset=1 for 1 cycle -> next edge gnt=0, ptr=0. After reset, req=8'h88 -> grant goes to 3.
